// File: rtl/core_test_monitor.sv
// core_test_monitor: run monitor with pc/inst trace buffer, cycle watchdog and sticky pass/fail/timeout verdict
module core_test_monitor #(
  parameter int XLEN        = 32,
  parameter int GP_W        = 3,
  parameter int PASS_GP     = 1,
  parameter int TRACE_DEPTH = 16,
  parameter int SAMPLE_DIV  = 5,
  parameter int TIMEOUT     = 4096,
  parameter int CNT_W       = 32,
  localparam int AW = $clog2(TRACE_DEPTH),
  localparam int DW = $clog2(SAMPLE_DIV + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] inst,
  input  logic            exit,
  input  logic [GP_W-1:0] gp,
  input  logic [AW-1:0]   rd_idx,
  output logic [XLEN-1:0] rd_pc,
  output logic [XLEN-1:0] rd_inst,
  output logic [AW:0]     trace_count,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [1:0]      status,
  output logic            done,
  output logic [GP_W-1:0] gp_final
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cycle_q, cycle_d, sample_q, sample_d;
  logic [DW-1:0] div_q, div_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_addr;
  logic [AW:0] count_q, count_d;
  logic [1:0] status_q, status_d;
  logic done_q, done_d, we;
  logic [GP_W-1:0] gp_final_q, gp_final_d;
  logic [2*XLEN-1:0] mem_q [TRACE_DEPTH];
  logic [2*XLEN-1:0] rd_q;
  // Index 0 is the newest entry, so read backwards from the last write position
  assign rd_addr = wr_ptr_q - AW'(1) - rd_idx;
  // Next-state: counting, sampling and verdict all resolve on the same RUN edge
  always_comb begin
    state_d = state_q;
    cycle_d = cycle_q;
    sample_d = sample_q;
    div_d = div_q;
    wr_ptr_d = wr_ptr_q;
    count_d = count_q;
    status_d = status_q;
    done_d = done_q;
    gp_final_d = gp_final_q;
    we = 1'b0;
    if (state_q == S_IDLE && start) state_d = S_RUN;
    if (state_q == S_RUN) begin
      cycle_d = cycle_q + CNT_W'(1);
      we = div_q == DW'(SAMPLE_DIV - 1);
      div_d = we ? '0 : div_q + DW'(1);
      wr_ptr_d = we ? wr_ptr_q + AW'(1) : wr_ptr_q;
      count_d = (we && count_q != (AW+1)'(TRACE_DEPTH)) ? count_q + (AW+1)'(1) : count_q;
      sample_d = we ? sample_q + CNT_W'(1) : sample_q;
      if (exit || cycle_q == CNT_W'(TIMEOUT - 1)) begin
        status_d = !exit ? 2'd3 : (gp == GP_W'(PASS_GP)) ? 2'd1 : 2'd2;
        gp_final_d = gp;
        done_d = 1'b1;
        state_d = S_DONE;
      end
    end
  end
  // Control and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cycle_q <= '0;
      sample_q <= '0;
      div_q <= '0;
      wr_ptr_q <= '0;
      count_q <= '0;
      status_q <= '0;
      done_q <= 1'b0;
      gp_final_q <= '0;
    end else begin
      state_q <= state_d;
      cycle_q <= cycle_d;
      sample_q <= sample_d;
      div_q <= div_d;
      wr_ptr_q <= wr_ptr_d;
      count_q <= count_d;
      status_q <= status_d;
      done_q <= done_d;
      gp_final_q <= gp_final_d;
    end
  end
  // Trace storage has no reset; stale entries are masked by trace_count
  always_ff @(posedge clk) begin
    if (we && !rst) mem_q[wr_ptr_q] <= {pc, inst};
  end
  // Registered trace read port
  always_ff @(posedge clk) begin
    if (rst) rd_q <= '0;
    else rd_q <= mem_q[rd_addr];
  end
  assign {rd_pc, rd_inst} = rd_q;
  assign trace_count = count_q;
  assign cycle_cnt = cycle_q;
  assign sample_cnt = sample_q;
  assign status = status_q;
  assign done = done_q;
  assign gp_final = gp_final_q;
endmodule
